m_proc_mc: RTL and testbench

M_PROC_MC -- requirements
Module: m_proc_mc

---
 rtl/m_proc_mc.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_m_proc_mc.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_proc_mc.sv
// m_proc_mc: multi-cycle RV32 subset core (add, sub, addi, lui, lw, sw, beq, bne).
// Instruction memory, data memory and register file are separate sub-instances
// (m_imem, m_dmem, m_rf), each holding its storage in an array named mem.

// Read-only word memory; combinational read.
module m_proc_mc_rom #(
    parameter int unsigned P_WORDS = 64,
    parameter int unsigned P_AW    = $clog2(P_WORDS)
) (
    input  logic [P_AW-1:0] i_raddr,
    output logic [31:0]     o_rdata
);
    logic [31:0] mem [0:P_WORDS-1] = '{default: '0};

    assign o_rdata = mem[i_raddr];
endmodule

// Word RAM: combinational read, synchronous write.
module m_proc_mc_ram #(
    parameter int unsigned P_WORDS = 64,
    parameter int unsigned P_AW    = $clog2(P_WORDS)
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [P_AW-1:0] i_addr,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata
);
    logic [31:0] mem [0:P_WORDS-1] = '{default: '0};

    assign o_rdata = mem[i_addr];

    // Commit a store on the rising edge when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end
endmodule

// 32 x 32 register file; x0 reads zero and ignores writes.
module m_proc_mc_rf (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] mem [0:31] = '{default: '0};

    assign o_rd1 = (i_ra1 == 5'd0) ? '0 : mem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? '0 : mem[i_ra2];

    // Write-back port; writes to x0 are dropped.
    always_ff @(posedge i_clk) begin
        if (i_we && (i_wa != 5'd0)) begin
            mem[i_wa] <= i_wd;
        end
    end
endmodule

// Core top: FSM sequencer plus datapath.
module m_proc_mc #(
    parameter int unsigned P_IMEM_WORDS = 64,
    parameter int unsigned P_DMEM_WORDS = 64,
    parameter int unsigned P_HALT_REG   = 30
) (
    input  logic        w_clk,
    input  logic        w_rst,
    output logic [31:0] w_pc,
    output logic [2:0]  w_state,
    output logic        w_retire,
    output logic        w_halt
);
    localparam int unsigned LP_IAW = $clog2(P_IMEM_WORDS);
    localparam int unsigned LP_DAW = $clog2(P_DMEM_WORDS);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Architectural and inter-state registers
    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_alu;
    logic [31:0] r_mdr;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;

    // Decoded instruction class
    logic        w_is_add;
    logic        w_is_sub;
    logic        w_is_addi;
    logic        w_is_lui;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_alu;
    logic        w_is_mem;
    logic        w_halting;

    // Datapath wires
    logic [31:0] w_imm_dec;
    logic [31:0] w_alu_res;
    logic        w_taken;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_dmem_rdata;
    logic [31:0] w_rf_rd1;
    logic [31:0] w_rf_rd2;
    logic [31:0] w_rf_wdata;
    logic        w_rf_we;
    logic        w_dmem_we;
    logic [2:0]  w_state_nxt;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];

    // Only exact subset encodings are recognised; everything else falls through as a no-op.
    assign w_is_add  = (w_opcode == OP_REG) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
    assign w_is_sub  = (w_opcode == OP_REG) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0100000);
    assign w_is_addi = (w_opcode == OP_IMM) && (w_funct3 == 3'b000);
    assign w_is_lui  = (w_opcode == OP_LUI);
    assign w_is_lw   = (w_opcode == OP_LOAD)   && (w_funct3 == 3'b010);
    assign w_is_sw   = (w_opcode == OP_STORE)  && (w_funct3 == 3'b010);
    assign w_is_beq  = (w_opcode == OP_BRANCH) && (w_funct3 == 3'b000);
    assign w_is_bne  = (w_opcode == OP_BRANCH) && (w_funct3 == 3'b001);
    assign w_is_alu  = w_is_add | w_is_sub | w_is_addi | w_is_lui;
    assign w_is_mem  = w_is_lw | w_is_sw;
    assign w_halting = ({27'd0, w_rd} == P_HALT_REG);

    // Immediate generation by instruction format
    always_comb begin
        w_imm_dec = '0;
        case (w_opcode)
            OP_IMM, OP_LOAD: w_imm_dec = {{20{r_ir[31]}}, r_ir[31:20]};
            OP_STORE:        w_imm_dec = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            OP_BRANCH:       w_imm_dec = {{19{r_ir[31]}}, r_ir[31], r_ir[7],
                                          r_ir[30:25], r_ir[11:8], 1'b0};
            OP_LUI:          w_imm_dec = {r_ir[31:12], 12'd0};
            default:         w_imm_dec = '0;
        endcase
    end

    // ALU: register ops, immediate adds (addi and address calc) and lui pass-through
    always_comb begin
        w_alu_res = r_a + r_imm;
        if (w_is_add) begin
            w_alu_res = r_a + r_b;
        end else if (w_is_sub) begin
            w_alu_res = r_a - r_b;
        end else if (w_is_lui) begin
            w_alu_res = r_imm;
        end
    end

    assign w_taken     = w_is_beq ? (r_a == r_b) : (w_is_bne ? (r_a != r_b) : 1'b0);
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = r_pc + r_imm;

    // Memory writes are masked by reset so a reset edge never commits a write.
    assign w_rf_we    = (r_state == S_WB) && !w_rst;
    assign w_dmem_we  = (r_state == S_MEM) && w_is_sw && !w_rst;
    assign w_rf_wdata = w_is_lw ? r_mdr : r_alu;

    // Next-state selection
    always_comb begin
        w_state_nxt = S_IF;
        case (r_state)
            S_IF:    w_state_nxt = S_ID;
            S_ID:    w_state_nxt = S_EX;
            S_EX:    w_state_nxt = w_is_alu ? S_WB : (w_is_mem ? S_MEM : S_IF);
            S_MEM:   w_state_nxt = w_is_lw ? S_WB : S_IF;
            S_WB:    w_state_nxt = w_halting ? S_HALT : S_IF;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IF;
        endcase
    end

    // State and PC; PC advances only in the instruction's final state, and not on a halting write.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= S_IF;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_EX: begin
                    if (w_taken) begin
                        r_pc <= w_br_target;
                    end else if (!w_is_alu && !w_is_mem) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                S_MEM: begin
                    if (w_is_sw) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                S_WB: begin
                    if (!w_halting) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    // Inter-state datapath latches: IR in IF, operands/imm in ID, ALU in EX, load data in MEM
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_alu <= '0;
            r_mdr <= '0;
        end else begin
            case (r_state)
                S_IF:  r_ir <= w_imem_rdata;
                S_ID: begin
                    r_a   <= w_rf_rd1;
                    r_b   <= w_rf_rd2;
                    r_imm <= w_imm_dec;
                end
                S_EX:  r_alu <= w_alu_res;
                S_MEM: r_mdr <= w_dmem_rdata;
                default: ;
            endcase
        end
    end

    m_proc_mc_rom #(
        .P_WORDS (P_IMEM_WORDS),
        .P_AW    (LP_IAW)
    ) m_imem (
        .i_raddr (r_pc[LP_IAW+1:2]),
        .o_rdata (w_imem_rdata)
    );

    m_proc_mc_ram #(
        .P_WORDS (P_DMEM_WORDS),
        .P_AW    (LP_DAW)
    ) m_dmem (
        .i_clk   (w_clk),
        .i_we    (w_dmem_we),
        .i_addr  (r_alu[LP_DAW+1:2]),
        .i_wdata (r_b),
        .o_rdata (w_dmem_rdata)
    );

    m_proc_mc_rf m_rf (
        .i_clk (w_clk),
        .i_we  (w_rf_we),
        .i_wa  (w_rd),
        .i_wd  (w_rf_wdata),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rf_rd1),
        .o_rd2 (w_rf_rd2)
    );

    assign w_pc     = r_pc;
    assign w_state  = r_state;
    assign w_retire = (r_state == S_WB)
                    || ((r_state == S_MEM) && w_is_sw)
                    || ((r_state == S_EX) && !w_is_alu && !w_is_mem);
    assign w_halt   = (r_state == S_HALT);
endmodule

// File: tb/tb_m_proc_mc.sv
// Testbench for m_proc_mc: directed scenarios plus a random program run against
// an instruction-level reference model (per-instruction latency, PC, final RF/dmem).
module tb_m_proc_mc;
    localparam int IMW    = 64;
    localparam int DMW    = 64;
    localparam int HALT_R = 30;

    localparam int K_ADD  = 0;
    localparam int K_SUB  = 1;
    localparam int K_ADDI = 2;
    localparam int K_LUI  = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_BNE  = 7;
    localparam int K_NOP  = 8;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        retire;
    logic        halt;

    m_proc_mc #(
        .P_IMEM_WORDS (IMW),
        .P_DMEM_WORDS (DMW),
        .P_HALT_REG   (HALT_R)
    ) dut (
        .w_clk    (clk),
        .w_rst    (rst),
        .w_pc     (pc),
        .w_state  (state),
        .w_retire (retire),
        .w_halt   (halt)
    );

    instr_t      prog [IMW];
    logic [31:0] mrf  [32];
    logic [31:0] mdm  [DMW];
    logic [31:0] mpc;
    int          errs   = 0;
    int          checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(int k, int rd, int rs1, int rs2, int imm);
        instr_t t;
        t.kind = k;
        t.rd   = 5'(rd);
        t.rs1  = 5'(rs1);
        t.rs2  = 5'(rs2);
        t.imm  = 32'(imm);
        return t;
    endfunction

    function automatic logic [31:0] enc(instr_t t);
        logic [31:0] i;
        i = t.imm;
        case (t.kind)
            K_ADD:  return {7'b0000000, t.rs2, t.rs1, 3'b000, t.rd, 7'b0110011};
            K_SUB:  return {7'b0100000, t.rs2, t.rs1, 3'b000, t.rd, 7'b0110011};
            K_ADDI: return {i[11:0], t.rs1, 3'b000, t.rd, 7'b0010011};
            K_LUI:  return {i[31:12], t.rd, 7'b0110111};
            K_LW:   return {i[11:0], t.rs1, 3'b010, t.rd, 7'b0000011};
            K_SW:   return {i[11:5], t.rs2, t.rs1, 3'b010, i[4:0], 7'b0100011};
            K_BEQ:  return {i[12], i[10:5], t.rs2, t.rs1, 3'b000, i[4:1], i[11], 7'b1100011};
            K_BNE:  return {i[12], i[10:5], t.rs2, t.rs1, 3'b001, i[4:1], i[11], 7'b1100011};
            default: return t.imm;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t      t;
        logic [31:0] w;
        int          k;
        k = $urandom_range(0, 8);
        t = mk(k, $urandom_range(0, 29), $urandom_range(0, 31), $urandom_range(0, 31), 0);
        case (k)
            K_ADDI, K_LW, K_SW: t.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            K_LUI:              t.imm = $urandom & 32'hFFFF_F000;
            K_BEQ, K_BNE:       t.imm = (32'($urandom_range(0, 31)) - 32'd16) << 2;
            K_NOP: begin
                w = $urandom;
                // either a non-subset opcode or an R-type with an unknown funct7 (mul)
                if ($urandom_range(0, 1) == 0) w[6:0] = 7'b0001111;
                else begin
                    w[31:25] = 7'b0000001;
                    w[14:12] = 3'b000;
                    w[6:0]   = 7'b0110011;
                end
                t.imm = w;
            end
            default: ;
        endcase
        return t;
    endfunction

    // Reference: execute one instruction architecturally; returns cycle latency and halt flag.
    task automatic model_step(output int lat, output bit hlt);
        instr_t      t;
        logic [31:0] a, b, v, nxt;
        int          di;
        bit          wr;
        t   = prog[int'((mpc >> 2) & 32'(IMW - 1))];
        a   = mrf[t.rs1];
        b   = mrf[t.rs2];
        v   = '0;
        wr  = 0;
        hlt = 0;
        lat = 3;
        nxt = mpc + 32'd4;
        di  = int'(((a + t.imm) >> 2) & 32'(DMW - 1));
        case (t.kind)
            K_ADD:  begin v = a + b;     wr = 1; lat = 4; end
            K_SUB:  begin v = a - b;     wr = 1; lat = 4; end
            K_ADDI: begin v = a + t.imm; wr = 1; lat = 4; end
            K_LUI:  begin v = t.imm;     wr = 1; lat = 4; end
            K_LW:   begin v = mdm[di];   wr = 1; lat = 5; end
            K_SW:   begin mdm[di] = b;   lat = 4; end
            K_BEQ:  if (a == b) nxt = mpc + t.imm;
            K_BNE:  if (a != b) nxt = mpc + t.imm;
            default: ;
        endcase
        if (wr) begin
            if (t.rd != 5'd0) mrf[t.rd] = v;
            if (int'(t.rd) == HALT_R) hlt = 1;
        end
        if (!hlt) mpc = nxt;
    endtask

    task automatic clear_model();
        for (int i = 0; i < IMW; i++) prog[i] = mk(K_NOP, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)  mrf[i] = '0;
        for (int i = 0; i < DMW; i++) mdm[i] = '0;
        mpc = '0;
    endtask

    // Hold reset, mirror the model's memories into the DUT, then release at cycle 1 (IF).
    task automatic load_dut();
        rst = 1'b1;
        for (int i = 0; i < IMW; i++) dut.m_imem.mem[i] = enc(prog[i]);
        for (int i = 0; i < 32; i++)  dut.m_rf.mem[i] = mrf[i];
        for (int i = 0; i < DMW; i++) dut.m_dmem.mem[i] = mdm[i];
        step();
        step();
        rst = 1'b0;
    endtask

    // Run one instruction; check retire cycle, PC after retirement and halt flag.
    task automatic run_instr(input string tag);
        int lat;
        int cyc;
        bit hlt;
        model_step(lat, hlt);
        cyc = 1;
        while (retire !== 1'b1 && cyc < 16) begin
            step();
            cyc++;
        end
        checks++;
        if (retire !== 1'b1 || cyc != lat) begin
            errs++;
            $display("FAIL %s_latency: retire=%b at cycle %0d, expected retire at cycle %0d", tag, retire, cyc, lat);
        end
        step();
        checks++;
        if (pc !== mpc) begin
            errs++;
            $display("FAIL %s_pc: got %h expected %h", tag, pc, mpc);
        end
        checks++;
        if (halt !== hlt) begin
            errs++;
            $display("FAIL %s_halt: got %b expected %b", tag, halt, hlt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (state !== 3'd0 || pc !== 32'd0 || retire !== 1'b0 || halt !== 1'b0) begin
            errs++;
            $display("FAIL reset: state=%0d pc=%h retire=%b halt=%b expected state=0 pc=0 retire=0 halt=0",
                     state, pc, retire, halt);
        end
    endtask

    task automatic test_add();
        clear_model();
        mrf[1] = 32'd5;
        mrf[2] = 32'd6;
        prog[0] = mk(K_ADD, 5, 1, 2, 0);
        load_dut();
        run_instr("add");
        checks++;
        if (dut.m_rf.mem[5] !== 32'd11 || pc !== 32'd4) begin
            errs++;
            $display("FAIL add_result: x5=%h pc=%h expected x5=0000000b pc=00000004", dut.m_rf.mem[5], pc);
        end
    endtask

    task automatic test_sub();
        clear_model();
        mrf[1] = 32'd0;
        mrf[2] = 32'd1;
        prog[0] = mk(K_SUB, 3, 1, 2, 0);
        load_dut();
        run_instr("sub");
        checks++;
        if (dut.m_rf.mem[3] !== 32'hFFFF_FFFF) begin
            errs++;
            $display("FAIL sub_wrap: x3=%h expected ffffffff", dut.m_rf.mem[3]);
        end
    endtask

    task automatic test_sw_lw();
        clear_model();
        mrf[1] = 32'd8;
        mrf[2] = 32'h1234;
        prog[0] = mk(K_SW, 0, 1, 2, 4);
        prog[1] = mk(K_LW, 3, 1, 0, 4);
        load_dut();
        run_instr("sw");
        run_instr("lw");
        checks++;
        if (dut.m_dmem.mem[3] !== 32'h1234 || dut.m_rf.mem[3] !== 32'h1234) begin
            errs++;
            $display("FAIL sw_lw: dmem[3]=%h x3=%h expected 00001234 both", dut.m_dmem.mem[3], dut.m_rf.mem[3]);
        end
    endtask

    task automatic test_branch();
        for (int v = 2; v >= 1; v--) begin
            clear_model();
            mrf[1] = 32'd1;
            mrf[2] = 32'(v);
            prog[0] = mk(K_BNE, 0, 1, 2, 8);
            load_dut();
            run_instr("bne");
            checks++;
            if (pc !== ((v == 2) ? 32'd8 : 32'd4)) begin
                errs++;
                $display("FAIL bne_target: x2=%0d pc=%h expected %h", v, pc, (v == 2) ? 32'd8 : 32'd4);
            end
        end
    endtask

    task automatic test_halt();
        clear_model();
        prog[0] = mk(K_ADDI, 0, 0, 0, 7);
        prog[1] = mk(K_ADDI, HALT_R, 0, 0, 9);
        load_dut();
        run_instr("addi_x0");
        run_instr("addi_halt");
        checks++;
        if (dut.m_rf.mem[0] !== 32'd0 || dut.m_rf.mem[30] !== 32'd9) begin
            errs++;
            $display("FAIL halt_regs: x0=%h x30=%h expected 0 and 9", dut.m_rf.mem[0], dut.m_rf.mem[30]);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (pc !== 32'd4 || halt !== 1'b1 || retire !== 1'b0 || state !== 3'd5) begin
                errs++;
                $display("FAIL halt_frozen: cycle %0d pc=%h halt=%b retire=%b state=%0d expected pc=4 halt=1 retire=0 state=5",
                         i, pc, halt, retire, state);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (state !== 3'd0 || halt !== 1'b0 || pc !== 32'd0 || dut.m_rf.mem[30] !== 32'd9) begin
            errs++;
            $display("FAIL halt_reset: state=%0d halt=%b pc=%h x30=%h expected 0/0/0/9",
                     state, halt, pc, dut.m_rf.mem[30]);
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        mrf[1] = 32'd5;
        mrf[2] = 32'd6;
        prog[0] = mk(K_ADD, 5, 1, 2, 0);
        load_dut();
        step();
        step();
        step();
        checks++;
        if (state !== 3'd4) begin
            errs++;
            $display("FAIL mid_reach_wb: state=%0d expected 4", state);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dut.m_rf.mem[5] !== 32'd0 || state !== 3'd0 || pc !== 32'd0) begin
            errs++;
            $display("FAIL mid_reset: x5=%h state=%0d pc=%h expected 0/0/0", dut.m_rf.mem[5], state, pc);
        end
    endtask

    task automatic test_random();
        clear_model();
        for (int i = 1; i < 32; i++)  mrf[i] = $urandom;
        for (int i = 0; i < DMW; i++) mdm[i] = $urandom;
        for (int i = 0; i < IMW; i++) prog[i] = rand_instr();
        load_dut();
        for (int n = 0; n < 150; n++) run_instr("rand");
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.m_rf.mem[i] !== mrf[i]) begin
                errs++;
                $display("FAIL rand_rf: x%0d=%h expected %h", i, dut.m_rf.mem[i], mrf[i]);
            end
        end
        for (int i = 0; i < DMW; i++) begin
            checks++;
            if (dut.m_dmem.mem[i] !== mdm[i]) begin
                errs++;
                $display("FAIL rand_dmem: dmem[%0d]=%h expected %h", i, dut.m_dmem.mem[i], mdm[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_sw_lw();
        test_branch();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
